// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_e   : responder FSM states (idle, waiting on latency, done)
//   WordWidth      : data word width in bits
//   DefaultDepth   : default backing-store depth in words
//   DefaultLatency : default stalled cycles per non-buffered access
package dmem_pkg;

  localparam int unsigned WordWidth      = 16;
  localparam int unsigned DefaultDepth   = 1024;
  localparam int unsigned DefaultLatency = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port backing store, DEPTH x WIDTH.
// Synchronous write, asynchronous read, shared address.
// Ports:
//   clk   in  : clock
//   we    in  : write enable, commits wdata at addr on the rising edge
//   addr  in  : word address, shared by read and write
//   wdata in  : write data
//   rdata out : combinational read of mem[addr]
// Contents are never cleared.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned WIDTH = WordWidth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with fixed multi-cycle latency.
// Accepts one read or write at a time, stalls the pipeline while the access is in flight,
// then pulses rdy for one cycle (with read data for reads).
// Ports:
//   clk      in  : clock, rising-edge
//   rst      in  : synchronous active-high reset
//   re       in  : read request
//   we       in  : write request (wins over re)
//   addr     in  : word address, wraps modulo DEPTH
//   wrt_data in  : write data
//   rd_data  out : read data, held until the next read completes
//   rdy      out : one-cycle completion pulse
//   stall    out : combinational pipeline freeze
//   err      out : one-cycle pulse, re and we both high at acceptance
// Build option: define DMEM_LINEBUF_EN to add a one-entry read line buffer; a read hit in
// idle completes in the same cycle without stalling.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DefaultDepth,
  parameter int unsigned LATENCY = DefaultLatency
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 re,
  input  logic                 we,
  input  logic [15:0]          addr,
  input  logic [WordWidth-1:0] wrt_data,
  output logic [WordWidth-1:0] rd_data,
  output logic                 rdy,
  output logic                 stall,
  output logic                 err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  // Keep the counter at least one bit wide so LATENCY==1 still elaborates.
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = (LATENCY > 1) ? CntW'(LATENCY - 2) : '0;

  dmem_state_e          state_q;
  logic [CntW-1:0]      cnt_q;
  logic [AW-1:0]        addr_q;
  logic [WordWidth-1:0] wdata_q;
  logic                 op_we_q;
  logic                 rdy_q;
  logic                 err_q;
  logic [WordWidth-1:0] rd_data_q;

  logic [AW-1:0]        arr_addr;
  logic                 arr_we;
  logic [WordWidth-1:0] arr_rdata;

  logic                 hit;
  logic [WordWidth-1:0] hit_data;

  // Upper address bits are intentionally ignored (address wraps).
  logic unused_addr;
  assign unused_addr = ^addr;

  // In idle the array is addressed straight from the request so a LATENCY==1 read can
  // capture data on acceptance; otherwise the latched request drives it.
  assign arr_addr = (state_q == StIdle) ? addr[AW-1:0] : addr_q;
  // Gate with rst so an abort from done never commits the write.
  assign arr_we   = (state_q == StDone) && op_we_q && !rst;

  dmem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WordWidth)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

`ifdef DMEM_LINEBUF_EN
  logic                 buf_valid_q;
  logic [AW-1:0]        buf_addr_q;
  logic [WordWidth-1:0] buf_data_q;

  // Refilled on every completed access; a completed write leaves its own data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (state_q == StDone) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= addr_q;
      buf_data_q  <= op_we_q ? wdata_q : arr_rdata;
    end
  end

  assign hit      = (state_q == StIdle) && re && !we && buf_valid_q &&
                    (buf_addr_q == addr[AW-1:0]);
  assign hit_data = buf_data_q;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_we_q   <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            // Hold buffered data on rd_data after the same-cycle hit.
            rd_data_q <= hit_data;
          end else if (re || we) begin
            addr_q  <= addr[AW-1:0];
            wdata_q <= wrt_data;
            op_we_q <= we;
            err_q   <= re && we;
            if (LATENCY == 1) begin
              state_q <= StDone;
              rdy_q   <= 1'b1;
              if (!we) begin
                rd_data_q <= arr_rdata;
              end
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StDone;
            rdy_q   <= 1'b1;
            // Any earlier write has already committed, so this sees fresh data.
            if (!op_we_q) begin
              rd_data_q <= arr_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign stall   = ((state_q == StIdle) && (re || we) && !hit) || (state_q == StWait);
  assign rdy     = rdy_q || hit;
  assign err     = err_q;
  assign rd_data = hit ? hit_data : rd_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wrt_data;
  logic [15:0] rd_data;
  logic        rdy;
  logic        stall;
  logic        err;

  int n_checks;
  int n_fail;

`ifdef DMEM_LINEBUF_EN
  // A read right after a write to the same address hits the buffer.
  localparam int RawStalls = 0;
`else
  localparam int RawStalls = 4;
`endif

  dmem_responder #(
    .DEPTH   (1024),
    .LATENCY (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .re       (re),
    .we       (we),
    .addr     (addr),
    .wrt_data (wrt_data),
    .rd_data  (rd_data),
    .rdy      (rdy),
    .stall    (stall),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access and observes it until rdy (bounded); no checking here.
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic hold,
                        output int stalls, output int errs, output logic got,
                        output logic [15:0] data, output logic rdy_stall);
    int cyc;
    @(posedge clk); #1;
    re = r; we = w; addr = a; wrt_data = d;
    stalls = 0; errs = 0; got = 1'b0; data = '0; rdy_stall = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (err) errs++;
      if (rdy) begin
        got = 1'b1; data = rd_data; rdy_stall = stall;
      end else if (stall) begin
        stalls++;
      end
      cyc++;
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      re = 1'b0; we = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wrt_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int s, e; logic g, rs; logic [15:0] dat;
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, s, e, g, dat, rs);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL wr_rdy: got %b want 1", g); end
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL wr_stalls: got %0d want 4", s); end
    n_checks++; if (rs !== 1'b0) begin n_fail++; $display("FAIL wr_rdy_and_stall: got %b want 0", rs); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL wr_err: got %0d want 0", e); end
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, s, e, g, dat, rs);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL rd_rdy: got %b want 1", g); end
    n_checks++; if (s !== RawStalls) begin n_fail++; $display("FAIL rd_stalls: got %0d want %0d", s, RawStalls); end
    n_checks++; if (dat !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", dat); end
    n_checks++; if (rs !== 1'b0) begin n_fail++; $display("FAIL rd_rdy_and_stall: got %b want 0", rs); end
  endtask

  task automatic test_addr_wrap();
    int s, e; logic g, rs; logic [15:0] dat;
    access(1'b0, 1'b1, 16'h0405, 16'h1234, 1'b0, s, e, g, dat, rs);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, s, e, g, dat, rs);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL wrap_rdy: got %b want 1", g); end
    n_checks++; if (dat !== 16'h1234) begin n_fail++; $display("FAIL wrap_data: got %h want 1234", dat); end
  endtask

  task automatic test_re_we();
    int s, e; logic g, rs; logic [15:0] dat;
    access(1'b1, 1'b1, 16'h0020, 16'h00AA, 1'b0, s, e, g, dat, rs);
    n_checks++; if (e !== 1) begin n_fail++; $display("FAIL both_err_pulses: got %0d want 1", e); end
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL both_stalls: got %0d want 4", s); end
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, s, e, g, dat, rs);
    n_checks++; if (dat !== 16'h00AA) begin n_fail++; $display("FAIL both_read_data: got %h want 00aa", dat); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL both_read_err: got %0d want 0", e); end
  endtask

  task automatic test_reset_in_wait();
    int s, e; logic g, rs; logic [15:0] dat;
    access(1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, s, e, g, dat, rs);
    @(posedge clk); #1;
    we = 1'b1; addr = 16'h0030; wrt_data = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rstw_second_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rstw_rdy: got %b want 0", rdy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstw_stall: got %b want 0", stall); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstw_err: got %b want 0", err); end
    n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rstw_rd_data: got %h want 0000", rd_data); end
    access(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, s, e, g, dat, rs);
    n_checks++; if (dat !== 16'h0000) begin n_fail++; $display("FAIL rstw_no_commit: got %h want 0000", dat); end
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL rstw_read_stalls: got %0d want 4", s); end
  endtask

  task automatic test_input_change_wait();
    int s, e, cyc; logic g, rs; logic [15:0] dat;
    access(1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0, s, e, g, dat, rs);
    access(1'b0, 1'b1, 16'h0041, 16'h2222, 1'b0, s, e, g, dat, rs);
    @(posedge clk); #1;
    re = 1'b1; addr = 16'h0040;
    @(posedge clk); #1;
    addr = 16'h0041;
    g = 1'b0; cyc = 0; dat = '0;
    while (!g && cyc < 20) begin
      @(negedge clk);
      if (rdy) begin g = 1'b1; dat = rd_data; end
      cyc++;
      if (!g) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    re = 1'b0;
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL chg_rdy: got %b want 1", g); end
    n_checks++; if (dat !== 16'h1111) begin n_fail++; $display("FAIL chg_data: got %h want 1111", dat); end
    // rdy arrives 4 cycles after the address change (5 after request).
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL chg_latency: got %0d want 4", cyc); end
  endtask

  task automatic test_back_to_back();
    int s, e; logic g, rs; logic [15:0] dat;
    access(1'b0, 1'b1, 16'h0050, 16'h7777, 1'b0, s, e, g, dat, rs);
    access(1'b0, 1'b1, 16'h0051, 16'h8888, 1'b0, s, e, g, dat, rs);
    // Request stays asserted past its DONE cycle.
    access(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1, s, e, g, dat, rs);
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL b2b_first_stalls: got %0d want 4", s); end
    n_checks++; if (dat !== 16'h7777) begin n_fail++; $display("FAIL b2b_first_data: got %h want 7777", dat); end
    @(posedge clk);
    @(negedge clk);
`ifdef DMEM_LINEBUF_EN
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL lbuf_hit_rdy: got %b want 1", rdy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lbuf_hit_stall: got %b want 0", stall); end
    n_checks++; if (rd_data !== 16'h7777) begin n_fail++; $display("FAIL lbuf_hit_data: got %h want 7777", rd_data); end
`else
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL held_rdy: got %b want 0", rdy); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL held_stall: got %b want 1", stall); end
`endif
    @(posedge clk); #1;
    re = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read();
    test_addr_wrap();
    test_re_we();
    test_reset_in_wait();
    test_input_change_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
